// File: rtl/knapsack_search_if.sv
// Host-side bundle for the knapsack search engine: start/operands in, status/results out.
interface knapsack_search_if #(
  parameter int unsigned N      = 5,
  parameter int unsigned ITEM_W = 8
);
  localparam int unsigned SUM_W = ITEM_W + $clog2(N + 1);

  logic                start;
  logic [N*ITEM_W-1:0] values;
  logic [N*ITEM_W-1:0] weights;
  logic [SUM_W-1:0]    capacity;
  logic [SUM_W-1:0]    min_value;
  logic                busy;
  logic                done;
  logic [N-1:0]        cand_sel;
  logic [N-1:0]        best_sel;
  logic [SUM_W-1:0]    best_value;
  logic [SUM_W-1:0]    best_weight;
  logic                found;

  // Host side: issues a search and observes the result.
  modport master (
    output start, values, weights, capacity, min_value,
    input  busy, done, cand_sel, best_sel, best_value, best_weight, found
  );

  // Engine side.
  modport slave (
    input  start, values, weights, capacity, min_value,
    output busy, done, cand_sel, best_sel, best_value, best_weight, found
  );
endinterface

// File: rtl/knapsack_search.sv
// Exhaustive 0-1 knapsack search: scans every item subset, one per cycle, and keeps the
// highest-value subset that fits the capacity. Lower-index subsets win ties.
module knapsack_search #(
  parameter int unsigned N      = 5,
  parameter int unsigned ITEM_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  knapsack_search_if.slave bus
);
  localparam int unsigned SUM_W = ITEM_W + $clog2(N + 1);
  localparam logic [N-1:0] LastIdx = '1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e              state_q, state_d;
  logic [N*ITEM_W-1:0] values_q, values_d;
  logic [N*ITEM_W-1:0] weights_q, weights_d;
  logic [SUM_W-1:0]    capacity_q, capacity_d;
  logic [SUM_W-1:0]    min_value_q, min_value_d;
  logic [N-1:0]        idx_q, idx_d;
  logic [N-1:0]        best_sel_q, best_sel_d;
  logic [SUM_W-1:0]    best_value_q, best_value_d;
  logic [SUM_W-1:0]    best_weight_q, best_weight_d;
  logic                found_q, found_d;

  logic [SUM_W-1:0]    cand_v;
  logic [SUM_W-1:0]    cand_w;
  logic                cand_better;

  // Totals of the subset selected by idx over the latched items; SUM_W is wide enough
  // for N full-scale items, so no overflow.
  always_comb begin
    cand_v = '0;
    cand_w = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q[i]) begin
        cand_v = cand_v + SUM_W'(values_q[i*ITEM_W +: ITEM_W]);
        cand_w = cand_w + SUM_W'(weights_q[i*ITEM_W +: ITEM_W]);
      end
    end
  end

  // Empty subset always fits and seeds best_*; afterwards only a strictly larger value wins.
  assign cand_better = (cand_w <= capacity_q) && ((idx_q == '0) || (cand_v > best_value_q));

  // Next-state and datapath updates for the IDLE -> SCAN -> DONE sequence.
  always_comb begin
    state_d       = state_q;
    values_d      = values_q;
    weights_d     = weights_q;
    capacity_d    = capacity_q;
    min_value_d   = min_value_q;
    idx_d         = idx_q;
    best_sel_d    = best_sel_q;
    best_value_d  = best_value_q;
    best_weight_d = best_weight_q;
    found_d       = found_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          values_d      = bus.values;
          weights_d     = bus.weights;
          capacity_d    = bus.capacity;
          min_value_d   = bus.min_value;
          idx_d         = '0;
          best_sel_d    = '0;
          best_value_d  = '0;
          best_weight_d = '0;
          found_d       = 1'b0;
          state_d       = StScan;
        end
      end
      StScan: begin
        if (cand_better) begin
          best_sel_d    = idx_q;
          best_value_d  = cand_v;
          best_weight_d = cand_w;
        end
        // Terminate on the last subset by compare so idx never has to wrap.
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        found_d = (best_value_q >= min_value_q);
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched operands, scan counter and best-so-far registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      values_q      <= '0;
      weights_q     <= '0;
      capacity_q    <= '0;
      min_value_q   <= '0;
      idx_q         <= '0;
      best_sel_q    <= '0;
      best_value_q  <= '0;
      best_weight_q <= '0;
      found_q       <= 1'b0;
    end else begin
      values_q      <= values_d;
      weights_q     <= weights_d;
      capacity_q    <= capacity_d;
      min_value_q   <= min_value_d;
      idx_q         <= idx_d;
      best_sel_q    <= best_sel_d;
      best_value_q  <= best_value_d;
      best_weight_q <= best_weight_d;
      found_q       <= found_d;
    end
  end

  // Status and result outputs; cand_sel is forced to zero outside the scan.
  always_comb begin
    bus.busy        = (state_q == StScan);
    bus.done        = (state_q == StDone);
    bus.cand_sel    = (state_q == StScan) ? idx_q : '0;
    bus.best_sel    = best_sel_q;
    bus.best_value  = best_value_q;
    bus.best_weight = best_weight_q;
    bus.found       = found_q;
  end

endmodule

// File: tb/tb_knapsack_search.sv
// Self-checking bench for knapsack_search: directed scenarios plus random item sets checked
// against a brute-force subset model.
module tb_knapsack_search;
  localparam int unsigned N      = 5;
  localparam int unsigned ITEM_W = 8;
  localparam int unsigned SUM_W  = ITEM_W + $clog2(N + 1);
  localparam int unsigned NSUB   = 1 << N;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  knapsack_search_if #(.N(N), .ITEM_W(ITEM_W)) bus ();

  knapsack_search #(.N(N), .ITEM_W(ITEM_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Brute force over all subsets: best = highest total value within capacity,
  // earliest subset index on ties, empty subset by default.
  function automatic void model(input logic [N*ITEM_W-1:0] v, input logic [N*ITEM_W-1:0] w,
                                input int cap, input int mn, output int bsel, output int bv,
                                output int bw, output logic fnd);
    int tv;
    int tw;
    bsel = 0;
    bv   = 0;
    bw   = 0;
    for (int s = 0; s < int'(NSUB); s++) begin
      tv = 0;
      tw = 0;
      for (int i = 0; i < int'(N); i++) begin
        if (s[i]) begin
          tv += int'(v[i*ITEM_W +: ITEM_W]);
          tw += int'(w[i*ITEM_W +: ITEM_W]);
        end
      end
      if (tw <= cap && tv > bv) begin
        bsel = s;
        bv   = tv;
        bw   = tw;
      end
    end
    fnd = (bv >= mn);
  endfunction

  // One full search with cycle-exact checks; inputs are scrambled after acceptance.
  task automatic run(input string name, input logic [N*ITEM_W-1:0] v,
                     input logic [N*ITEM_W-1:0] w, input logic [SUM_W-1:0] cap,
                     input logic [SUM_W-1:0] mn, input bit poke);
    int   esel;
    int   ev;
    int   ew;
    logic efound;
    model(v, w, int'(cap), int'(mn), esel, ev, ew, efound);
    bus.values    = v;
    bus.weights   = w;
    bus.capacity  = cap;
    bus.min_value = mn;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.values    = {$urandom, $urandom};
    bus.weights   = {$urandom, $urandom};
    bus.capacity  = SUM_W'($urandom);
    bus.min_value = SUM_W'($urandom);
    for (int k = 0; k < int'(NSUB); k++) begin
      check($sformatf("%s.busy[%0d]", name, k), bus.busy, 1);
      check($sformatf("%s.done_early[%0d]", name, k), bus.done, 0);
      check($sformatf("%s.cand_sel[%0d]", name, k), bus.cand_sel, k);
      bus.start = (poke && k == 5);
      tick();
    end
    bus.start = 1'b0;
    check({name, ".done"}, bus.done, 1);
    check({name, ".busy_in_done"}, bus.busy, 0);
    check({name, ".cand_sel_in_done"}, bus.cand_sel, 0);
    check({name, ".best_sel"}, bus.best_sel, esel);
    check({name, ".best_value"}, bus.best_value, ev);
    check({name, ".best_weight"}, bus.best_weight, ew);
    bus.start = poke;
    tick();
    bus.start = 1'b0;
    check({name, ".done_pulse"}, bus.done, 0);
    check({name, ".found"}, bus.found, efound);
    check({name, ".best_sel_hold"}, bus.best_sel, esel);
    check({name, ".best_value_hold"}, bus.best_value, ev);
    if (poke) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        check($sformatf("%s.idle_busy[%0d]", name, k), bus.busy, 0);
        check($sformatf("%s.idle_done[%0d]", name, k), bus.done, 0);
      end
    end
  endtask

  logic [N*ITEM_W-1:0] sv1, sw1, ones, rv, rw;

  initial begin
    sv1  = {8'd10, 8'd1, 8'd2, 8'd2, 8'd4};
    sw1  = {8'd4, 8'd1, 8'd2, 8'd1, 8'd12};
    ones = {N{8'd1}};
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.values    = '0;
    bus.weights   = '0;
    bus.capacity  = '0;
    bus.min_value = '0;
    tick();
    tick();
    check("rst.busy", bus.busy, 0);
    check("rst.done", bus.done, 0);
    check("rst.cand_sel", bus.cand_sel, 0);
    check("rst.best_sel", bus.best_sel, 0);
    check("rst.best_value", bus.best_value, 0);
    check("rst.best_weight", bus.best_weight, 0);
    check("rst.found", bus.found, 0);
    rst_n = 1'b1;
    tick();
    check("idle.busy", bus.busy, 0);

    run("s1", sv1, sw1, 15, 15, 1'b0);
    run("s2", sv1, sw1, 15, 16, 1'b0);
    run("s3a", sv1, sw1, 0, 0, 1'b0);
    run("s3b", sv1, sw1, 0, 3, 1'b0);
    run("s4", ones, ones, 2, 0, 1'b0);
    run("s5", sv1, sw1, 15, 15, 1'b1);

    // Reset in the middle of a scan aborts it without a done pulse.
    bus.values    = sv1;
    bus.weights   = sw1;
    bus.capacity  = 15;
    bus.min_value = 15;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    check("s6.busy_before_rst", bus.busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("s6.busy", bus.busy, 0);
    check("s6.done", bus.done, 0);
    check("s6.cand_sel", bus.cand_sel, 0);
    check("s6.best_sel", bus.best_sel, 0);
    check("s6.best_value", bus.best_value, 0);
    check("s6.best_weight", bus.best_weight, 0);
    for (int k = 0; k < 40; k++) begin
      tick();
      check($sformatf("s6.no_done[%0d]", k), bus.done, 0);
    end
    run("s6r", sv1, sw1, 15, 15, 1'b0);

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < int'(N); i++) begin
        rv[i*ITEM_W +: ITEM_W] = ITEM_W'($urandom_range(0, 255));
        rw[i*ITEM_W +: ITEM_W] = ITEM_W'($urandom_range(0, 255));
      end
      run($sformatf("rnd%0d", r), rv, rw, SUM_W'($urandom_range(0, 700)),
          SUM_W'($urandom_range(0, 900)), r[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
